// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating instruction fetch and the LSB onto
// the single byte-wide RAM/IO port; assembles little-endian read results.
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        rob_to_mc_clear,
    input  logic        if_to_mc_enable,
    input  logic [31:0] if_to_mc_pc,
    output logic        mc_to_if_done,
    output logic [31:0] mc_to_if_result,
    input  logic        lsb_to_mc_enable,
    input  logic        lsb_to_mc_wr,
    input  logic [1:0]  lsb_to_mc_size,
    input  logic [31:0] lsb_to_mc_addr,
    input  logic [31:0] lsb_to_mc_data,
    output logic        mc_to_lsb_done,
    output logic [31:0] mc_to_lsb_result,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    typedef enum logic [2:0] {
        IDLE,
        IF_READ,
        LSB_READ,
        LSB_WRITE,
        DONE
    } state_t;

    state_t      state, state_n;
    logic [2:0]  cnt, cnt_n;
    logic [2:0]  len, len_n;
    logic [31:0] addr, addr_n;
    logic [31:0] wdata, wdata_n;
    logic [31:0] rbuf, rbuf_n;
    logic        last_lsb, last_lsb_n;
    logic [31:0] mem_a_n;
    logic [7:0]  mem_dout_n;
    logic        mem_wr_n;
    logic        if_done_n, lsb_done_n;
    logic [31:0] if_result_n, lsb_result_n;

    logic [31:0] byte_addr;
    logic [31:0] assembled;
    logic [31:0] wshift;
    logic [2:0]  lsb_len;
    logic        lsb_req, grant_lsb, grant_if;

    // IO writes must wait while the output buffer is full.
    function automatic logic io_blocked(input logic [31:0] a, input logic full);
        return (a[17:16] == 2'b11) && full;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            cnt              <= '0;
            len              <= '0;
            addr             <= '0;
            wdata            <= '0;
            rbuf             <= '0;
            last_lsb         <= 1'b0;
            mem_a            <= '0;
            mem_dout         <= '0;
            mem_wr           <= 1'b0;
            mc_to_if_done    <= 1'b0;
            mc_to_lsb_done   <= 1'b0;
            mc_to_if_result  <= '0;
            mc_to_lsb_result <= '0;
        end else if (rdy) begin
            state            <= state_n;
            cnt              <= cnt_n;
            len              <= len_n;
            addr             <= addr_n;
            wdata            <= wdata_n;
            rbuf             <= rbuf_n;
            last_lsb         <= last_lsb_n;
            mem_a            <= mem_a_n;
            mem_dout         <= mem_dout_n;
            mem_wr           <= mem_wr_n;
            mc_to_if_done    <= if_done_n;
            mc_to_lsb_done   <= lsb_done_n;
            mc_to_if_result  <= if_result_n;
            mc_to_lsb_result <= lsb_result_n;
        end
    end

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        len_n        = len;
        addr_n       = addr;
        wdata_n      = wdata;
        rbuf_n       = rbuf;
        last_lsb_n   = last_lsb;
        mem_a_n      = mem_a;
        mem_dout_n   = mem_dout;
        mem_wr_n     = mem_wr;
        if_done_n    = mc_to_if_done;
        lsb_done_n   = mc_to_lsb_done;
        if_result_n  = mc_to_if_result;
        lsb_result_n = mc_to_lsb_result;

        byte_addr = addr + {29'd0, cnt};
        assembled = rbuf | ({24'd0, mem_din} << {cnt, 3'b000});
        wshift    = wdata >> {cnt, 3'b000};

        case (lsb_to_mc_size)
            2'd0:    lsb_len = 3'd1;
            2'd1:    lsb_len = 3'd2;
            default: lsb_len = 3'd4;
        endcase

        // A flush suppresses a pending load grant; stores are already committed.
        lsb_req   = lsb_to_mc_enable && !(rob_to_mc_clear && !lsb_to_mc_wr);
        grant_lsb = lsb_req && (!if_to_mc_enable || !last_lsb);
        grant_if  = if_to_mc_enable && !grant_lsb;

        case (state)
            IDLE: begin
                if (grant_if) begin
                    state_n    = IF_READ;
                    addr_n     = if_to_mc_pc;
                    len_n      = 3'd4;
                    cnt_n      = '0;
                    rbuf_n     = '0;
                    mem_a_n    = if_to_mc_pc;
                    mem_wr_n   = 1'b0;
                    last_lsb_n = 1'b0;
                end else if (grant_lsb) begin
                    addr_n     = lsb_to_mc_addr;
                    wdata_n    = lsb_to_mc_data;
                    len_n      = lsb_len;
                    cnt_n      = '0;
                    rbuf_n     = '0;
                    last_lsb_n = 1'b1;
                    if (lsb_to_mc_wr) begin
                        state_n = LSB_WRITE;
                        if (io_blocked(lsb_to_mc_addr, io_buffer_full)) begin
                            mem_wr_n   = 1'b0;
                            mem_a_n    = '0;
                            mem_dout_n = '0;
                        end else begin
                            mem_wr_n   = 1'b1;
                            mem_a_n    = lsb_to_mc_addr;
                            mem_dout_n = lsb_to_mc_data[7:0];
                            cnt_n      = 3'd1;
                        end
                    end else begin
                        state_n  = LSB_READ;
                        mem_a_n  = lsb_to_mc_addr;
                        mem_wr_n = 1'b0;
                    end
                end
            end

            IF_READ, LSB_READ: begin
                if (state == LSB_READ && rob_to_mc_clear) begin
                    state_n = IDLE;
                    mem_a_n = '0;
                end else begin
                    rbuf_n = assembled;
                    if (cnt == len - 3'd1) begin
                        state_n = DONE;
                        mem_a_n = '0;
                        if (state == IF_READ) begin
                            if_done_n   = 1'b1;
                            if_result_n = assembled;
                        end else begin
                            lsb_done_n   = 1'b1;
                            lsb_result_n = assembled;
                        end
                    end else begin
                        cnt_n   = cnt + 3'd1;
                        mem_a_n = byte_addr + 32'd1;
                    end
                end
            end

            // In LSB_WRITE, cnt counts bytes already placed on the bus.
            LSB_WRITE: begin
                if (cnt == len) begin
                    state_n    = DONE;
                    mem_wr_n   = 1'b0;
                    mem_dout_n = '0;
                    mem_a_n    = '0;
                    lsb_done_n = 1'b1;
                end else if (io_blocked(byte_addr, io_buffer_full)) begin
                    mem_wr_n   = 1'b0;
                    mem_dout_n = '0;
                    mem_a_n    = '0;
                end else begin
                    mem_wr_n   = 1'b1;
                    mem_a_n    = byte_addr;
                    mem_dout_n = wshift[7:0];
                    cnt_n      = cnt + 3'd1;
                end
            end

            DONE: begin
                state_n    = IDLE;
                if_done_n  = 1'b0;
                lsb_done_n = 1'b0;
            end

            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: fetch/load/store sequencing, arbitration,
// IO stall, flush, reset and rdy hold, all against hand-computed values.
module tb_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        rob_to_mc_clear;
    logic        if_to_mc_enable;
    logic [31:0] if_to_mc_pc;
    logic        mc_to_if_done;
    logic [31:0] mc_to_if_result;
    logic        lsb_to_mc_enable;
    logic        lsb_to_mc_wr;
    logic [1:0]  lsb_to_mc_size;
    logic [31:0] lsb_to_mc_addr;
    logic [31:0] lsb_to_mc_data;
    logic        mc_to_lsb_done;
    logic [31:0] mc_to_lsb_result;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    logic [7:0]  ram [0:1023];
    int          total;
    int          bad;

    mem_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .rdy              (rdy),
        .rob_to_mc_clear  (rob_to_mc_clear),
        .if_to_mc_enable  (if_to_mc_enable),
        .if_to_mc_pc      (if_to_mc_pc),
        .mc_to_if_done    (mc_to_if_done),
        .mc_to_if_result  (mc_to_if_result),
        .lsb_to_mc_enable (lsb_to_mc_enable),
        .lsb_to_mc_wr     (lsb_to_mc_wr),
        .lsb_to_mc_size   (lsb_to_mc_size),
        .lsb_to_mc_addr   (lsb_to_mc_addr),
        .lsb_to_mc_data   (lsb_to_mc_data),
        .mc_to_lsb_done   (mc_to_lsb_done),
        .mc_to_lsb_result (mc_to_lsb_result),
        .mem_din          (mem_din),
        .mem_dout         (mem_dout),
        .mem_a            (mem_a),
        .mem_wr           (mem_wr),
        .io_buffer_full   (io_buffer_full)
    );

    // Read data for the address presented after an edge is sampled on the next edge.
    assign mem_din = ram[mem_a[9:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (mem_a !== 32'h0) begin bad++; $display("FAIL reset_mem_a got=%h want=0", mem_a); end
        total++; if (mem_dout !== 8'h0) begin bad++; $display("FAIL reset_mem_dout got=%h want=0", mem_dout); end
        total++; if (mem_wr !== 1'b0) begin bad++; $display("FAIL reset_mem_wr got=%b want=0", mem_wr); end
        total++; if (mc_to_if_done !== 1'b0) begin bad++; $display("FAIL reset_if_done got=%b want=0", mc_to_if_done); end
        total++; if (mc_to_lsb_done !== 1'b0) begin bad++; $display("FAIL reset_lsb_done got=%b want=0", mc_to_lsb_done); end
        total++; if (mc_to_if_result !== 32'h0) begin bad++; $display("FAIL reset_if_result got=%h want=0", mc_to_if_result); end
        total++; if (mc_to_lsb_result !== 32'h0) begin bad++; $display("FAIL reset_lsb_result got=%h want=0", mc_to_lsb_result); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_if_fetch();
        if_to_mc_enable = 1'b1;
        if_to_mc_pc     = 32'h0000_0010;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++; if (mem_a !== 32'h10 + i) begin bad++; $display("FAIL fetch_addr[%0d] got=%h want=%h", i, mem_a, 32'h10 + i); end
            total++; if (mem_wr !== 1'b0 || mc_to_if_done !== 1'b0) begin bad++; $display("FAIL fetch_busy[%0d] wr=%b done=%b want 0/0", i, mem_wr, mc_to_if_done); end
        end
        @(negedge clk);
        total++; if (mc_to_if_done !== 1'b1) begin bad++; $display("FAIL fetch_done got=%b want=1", mc_to_if_done); end
        total++; if (mc_to_if_result !== 32'h0000_0013) begin bad++; $display("FAIL fetch_result got=%h want=00000013", mc_to_if_result); end
        total++; if (mem_a !== 32'h0) begin bad++; $display("FAIL fetch_addr_idle got=%h want=0", mem_a); end
        if_to_mc_enable = 1'b0;
        @(negedge clk);
        total++; if (mc_to_if_done !== 1'b0) begin bad++; $display("FAIL fetch_done_fall got=%b want=0", mc_to_if_done); end
    endtask

    task automatic test_lsb_lb();
        lsb_to_mc_enable = 1'b1;
        lsb_to_mc_wr     = 1'b0;
        lsb_to_mc_size   = 2'd0;
        lsb_to_mc_addr   = 32'h0000_0104;
        @(negedge clk);
        total++; if (mem_a !== 32'h104) begin bad++; $display("FAIL lb_addr got=%h want=00000104", mem_a); end
        @(negedge clk);
        total++; if (mc_to_lsb_done !== 1'b1) begin bad++; $display("FAIL lb_done got=%b want=1", mc_to_lsb_done); end
        total++; if (mc_to_lsb_result !== 32'h0000_0080) begin bad++; $display("FAIL lb_result got=%h want=00000080", mc_to_lsb_result); end
        total++; if (mc_to_if_result !== 32'h0000_0013 || mc_to_if_done !== 1'b0) begin bad++; $display("FAIL lb_if_hold result=%h done=%b want 00000013/0", mc_to_if_result, mc_to_if_done); end
        lsb_to_mc_enable = 1'b0;
        @(negedge clk);
        total++; if (mc_to_lsb_done !== 1'b0) begin bad++; $display("FAIL lb_done_fall got=%b want=0", mc_to_lsb_done); end
    endtask

    task automatic test_lsb_sh();
        logic [7:0] exp_d;
        lsb_to_mc_enable = 1'b1;
        lsb_to_mc_wr     = 1'b1;
        lsb_to_mc_size   = 2'd1;
        lsb_to_mc_addr   = 32'h0000_0200;
        lsb_to_mc_data   = 32'h1234_BEEF;
        for (int i = 0; i < 2; i++) begin
            exp_d = (i == 0) ? 8'hEF : 8'hBE;
            @(negedge clk);
            total++; if (mem_wr !== 1'b1 || mem_a !== 32'h200 + i || mem_dout !== exp_d) begin bad++; $display("FAIL sh_byte[%0d] wr=%b a=%h d=%h want 1/%h/%h", i, mem_wr, mem_a, mem_dout, 32'h200 + i, exp_d); end
            total++; if (mc_to_lsb_done !== 1'b0) begin bad++; $display("FAIL sh_early_done[%0d] got=%b want=0", i, mc_to_lsb_done); end
        end
        @(negedge clk);
        total++; if (mem_wr !== 1'b0 || mem_dout !== 8'h0) begin bad++; $display("FAIL sh_release wr=%b d=%h want 0/00", mem_wr, mem_dout); end
        total++; if (mc_to_lsb_done !== 1'b1) begin bad++; $display("FAIL sh_done got=%b want=1", mc_to_lsb_done); end
        lsb_to_mc_enable = 1'b0;
        @(negedge clk);
        total++; if (mc_to_lsb_done !== 1'b0 || mem_wr !== 1'b0) begin bad++; $display("FAIL sh_after done=%b wr=%b want 0/0", mc_to_lsb_done, mem_wr); end
    endtask

    task automatic test_back_to_back();
        logic lsb_turn;
        rst = 1'b1;
        @(negedge clk);
        rst              = 1'b0;
        if_to_mc_enable  = 1'b1;
        if_to_mc_pc      = 32'h0000_0020;
        lsb_to_mc_enable = 1'b1;
        lsb_to_mc_wr     = 1'b0;
        lsb_to_mc_size   = 2'd2;
        lsb_to_mc_addr   = 32'h0000_0040;
        for (int k = 0; k < 4; k++) begin
            lsb_turn = (k % 2 == 0);
            @(negedge clk);
            total++; if (mem_a !== (lsb_turn ? 32'h40 : 32'h20)) begin bad++; $display("FAIL tie_grant[%0d] got=%h want=%h", k, mem_a, lsb_turn ? 32'h40 : 32'h20); end
            repeat (3) @(negedge clk);
            @(negedge clk);
            if (lsb_turn) begin
                total++; if (mc_to_lsb_done !== 1'b1 || mc_to_if_done !== 1'b0) begin bad++; $display("FAIL tie_done[%0d] lsb=%b if=%b want 1/0", k, mc_to_lsb_done, mc_to_if_done); end
                total++; if (mc_to_lsb_result !== 32'hD4C3_B2A1) begin bad++; $display("FAIL tie_lsb_result[%0d] got=%h want=d4c3b2a1", k, mc_to_lsb_result); end
                lsb_to_mc_enable = 1'b0;
            end else begin
                total++; if (mc_to_if_done !== 1'b1 || mc_to_lsb_done !== 1'b0) begin bad++; $display("FAIL tie_done[%0d] if=%b lsb=%b want 1/0", k, mc_to_if_done, mc_to_lsb_done); end
                total++; if (mc_to_if_result !== 32'h0403_0201) begin bad++; $display("FAIL tie_if_result[%0d] got=%h want=04030201", k, mc_to_if_result); end
                if_to_mc_enable = 1'b0;
            end
            @(negedge clk);
            total++; if (mem_a !== 32'h0 || mc_to_if_done !== 1'b0 || mc_to_lsb_done !== 1'b0) begin bad++; $display("FAIL tie_dead[%0d] a=%h if=%b lsb=%b want 0/0/0", k, mem_a, mc_to_if_done, mc_to_lsb_done); end
            if_to_mc_enable  = 1'b1;
            lsb_to_mc_enable = 1'b1;
        end
        if_to_mc_enable  = 1'b0;
        lsb_to_mc_enable = 1'b0;
    endtask

    task automatic test_io_stall();
        lsb_to_mc_enable = 1'b1;
        lsb_to_mc_wr     = 1'b1;
        lsb_to_mc_size   = 2'd0;
        lsb_to_mc_addr   = 32'h0003_0000;
        lsb_to_mc_data   = 32'h0000_0041;
        io_buffer_full   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++; if (mem_wr !== 1'b0 || mc_to_lsb_done !== 1'b0) begin bad++; $display("FAIL io_stall[%0d] wr=%b done=%b want 0/0", i, mem_wr, mc_to_lsb_done); end
        end
        io_buffer_full = 1'b0;
        @(negedge clk);
        total++; if (mem_wr !== 1'b1 || mem_a !== 32'h0003_0000 || mem_dout !== 8'h41) begin bad++; $display("FAIL io_write wr=%b a=%h d=%h want 1/00030000/41", mem_wr, mem_a, mem_dout); end
        total++; if (mc_to_lsb_done !== 1'b0) begin bad++; $display("FAIL io_early_done got=%b want=0", mc_to_lsb_done); end
        @(negedge clk);
        total++; if (mem_wr !== 1'b0 || mc_to_lsb_done !== 1'b1) begin bad++; $display("FAIL io_done wr=%b done=%b want 0/1", mem_wr, mc_to_lsb_done); end
        lsb_to_mc_enable = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_clear();
        logic [31:0] sw_data;
        logic [7:0]  exp_d;
        // flush an in-flight word load after two bytes
        lsb_to_mc_enable = 1'b1;
        lsb_to_mc_wr     = 1'b0;
        lsb_to_mc_size   = 2'd2;
        lsb_to_mc_addr   = 32'h0000_0040;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (mem_a !== 32'h40 + i) begin bad++; $display("FAIL clr_load_addr[%0d] got=%h want=%h", i, mem_a, 32'h40 + i); end
        end
        rob_to_mc_clear = 1'b1;
        @(negedge clk);
        total++; if (mem_a !== 32'h0 || mc_to_lsb_done !== 1'b0) begin bad++; $display("FAIL clr_abort a=%h done=%b want 0/0", mem_a, mc_to_lsb_done); end
        rob_to_mc_clear  = 1'b0;
        lsb_to_mc_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (mem_a !== 32'h0 || mc_to_lsb_done !== 1'b0) begin bad++; $display("FAIL clr_quiet[%0d] a=%h done=%b want 0/0", i, mem_a, mc_to_lsb_done); end
        end
        // clear in IDLE blocks a load grant
        lsb_to_mc_enable = 1'b1;
        rob_to_mc_clear  = 1'b1;
        @(negedge clk);
        total++; if (mem_a !== 32'h0) begin bad++; $display("FAIL clr_idle_nogrant got=%h want=0", mem_a); end
        lsb_to_mc_enable = 1'b0;
        rob_to_mc_clear  = 1'b0;
        @(negedge clk);
        // fetch ignores clear
        if_to_mc_enable = 1'b1;
        if_to_mc_pc     = 32'h0000_0010;
        @(negedge clk);
        rob_to_mc_clear = 1'b1;
        @(negedge clk);
        rob_to_mc_clear = 1'b0;
        total++; if (mem_a !== 32'h11) begin bad++; $display("FAIL clr_fetch_addr got=%h want=00000011", mem_a); end
        repeat (2) @(negedge clk);
        @(negedge clk);
        total++; if (mc_to_if_done !== 1'b1 || mc_to_if_result !== 32'h0000_0013) begin bad++; $display("FAIL clr_fetch_done done=%b result=%h want 1/00000013", mc_to_if_done, mc_to_if_result); end
        if_to_mc_enable = 1'b0;
        @(negedge clk);
        // committed store ignores clear
        sw_data          = 32'hCAFE_F00D;
        lsb_to_mc_enable = 1'b1;
        lsb_to_mc_wr     = 1'b1;
        lsb_to_mc_size   = 2'd2;
        lsb_to_mc_addr   = 32'h0000_0300;
        lsb_to_mc_data   = sw_data;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            exp_d = sw_data[8*i +: 8];
            total++; if (mem_wr !== 1'b1 || mem_a !== 32'h300 + i || mem_dout !== exp_d) begin bad++; $display("FAIL clr_sw_byte[%0d] wr=%b a=%h d=%h want 1/%h/%h", i, mem_wr, mem_a, mem_dout, 32'h300 + i, exp_d); end
            rob_to_mc_clear = (i == 1);
        end
        @(negedge clk);
        total++; if (mc_to_lsb_done !== 1'b1 || mem_wr !== 1'b0) begin bad++; $display("FAIL clr_sw_done done=%b wr=%b want 1/0", mc_to_lsb_done, mem_wr); end
        lsb_to_mc_enable = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_write();
        lsb_to_mc_enable = 1'b1;
        lsb_to_mc_wr     = 1'b1;
        lsb_to_mc_size   = 2'd2;
        lsb_to_mc_addr   = 32'h0000_0300;
        lsb_to_mc_data   = 32'h1122_3344;
        repeat (2) @(negedge clk);
        total++; if (mem_wr !== 1'b1 || mem_a !== 32'h301) begin bad++; $display("FAIL rstw_pre wr=%b a=%h want 1/00000301", mem_wr, mem_a); end
        rst = 1'b1;
        @(negedge clk);
        total++; if (mem_wr !== 1'b0 || mem_a !== 32'h0 || mem_dout !== 8'h0) begin bad++; $display("FAIL rstw_bus wr=%b a=%h d=%h want 0/0/0", mem_wr, mem_a, mem_dout); end
        total++; if (mc_to_if_done !== 1'b0 || mc_to_lsb_done !== 1'b0) begin bad++; $display("FAIL rstw_done if=%b lsb=%b want 0/0", mc_to_if_done, mc_to_lsb_done); end
        total++; if (mc_to_if_result !== 32'h0 || mc_to_lsb_result !== 32'h0) begin bad++; $display("FAIL rstw_results if=%h lsb=%h want 0/0", mc_to_if_result, mc_to_lsb_result); end
        rst              = 1'b0;
        lsb_to_mc_enable = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_rdy_hold();
        if_to_mc_enable = 1'b1;
        if_to_mc_pc     = 32'h0000_0020;
        repeat (2) @(negedge clk);
        total++; if (mem_a !== 32'h21) begin bad++; $display("FAIL rdy_pre got=%h want=00000021", mem_a); end
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (mem_a !== 32'h21 || mc_to_if_done !== 1'b0) begin bad++; $display("FAIL rdy_frozen[%0d] a=%h done=%b want 00000021/0", i, mem_a, mc_to_if_done); end
        end
        rdy = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++; if (mem_a !== 32'h22 + i) begin bad++; $display("FAIL rdy_resume[%0d] got=%h want=%h", i, mem_a, 32'h22 + i); end
        end
        @(negedge clk);
        total++; if (mc_to_if_done !== 1'b1 || mc_to_if_result !== 32'h0403_0201) begin bad++; $display("FAIL rdy_result done=%b result=%h want 1/04030201", mc_to_if_done, mc_to_if_result); end
        if_to_mc_enable = 1'b0;
        @(negedge clk);
        total++; if (mc_to_if_done !== 1'b0) begin bad++; $display("FAIL rdy_done_fall got=%b want=0", mc_to_if_done); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int a = 0; a < 1024; a++) ram[a] = 8'h00;
        ram[10'h010] = 8'h13;
        ram[10'h014] = 8'hEE;
        ram[10'h020] = 8'h01; ram[10'h021] = 8'h02; ram[10'h022] = 8'h03; ram[10'h023] = 8'h04;
        ram[10'h040] = 8'hA1; ram[10'h041] = 8'hB2; ram[10'h042] = 8'hC3; ram[10'h043] = 8'hD4;
        ram[10'h104] = 8'h80; ram[10'h105] = 8'hFF;

        rst              = 1'b1;
        rdy              = 1'b1;
        rob_to_mc_clear  = 1'b0;
        if_to_mc_enable  = 1'b0;
        if_to_mc_pc      = '0;
        lsb_to_mc_enable = 1'b0;
        lsb_to_mc_wr     = 1'b0;
        lsb_to_mc_size   = '0;
        lsb_to_mc_addr   = '0;
        lsb_to_mc_data   = '0;
        io_buffer_full   = 1'b0;

        test_reset();
        test_if_fetch();
        test_lsb_lb();
        test_lsb_sh();
        test_back_to_back();
        test_io_stall();
        test_clear();
        test_reset_mid_write();
        test_rdy_hold();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Single-port memory controller that arbitrates between instruction fetch and the load/store buffer for the byte-wide RAM/IO port. It serialises 1/2/4-byte accesses into byte transfers, assembles little-endian read results and returns a one-cycle done pulse to the winning requester. It sits between the fetch unit (with its direct-mapped iCache) and the LSB on one side and the external RAM/IO bus on the other.

## Interface
- No parameters.
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rdy  in  1  global enable; when low, all state and outputs hold
- rob_to_mc_clear  in  1  misprediction flush; aborts an in-flight LSB load only
- if_to_mc_enable  in  1  fetch request, held until done
- if_to_mc_pc  in  32  fetch address (4-byte read)
- mc_to_if_done  out  1  one-cycle pulse: fetch result valid
- mc_to_if_result  out  32  fetched instruction
- lsb_to_mc_enable  in  1  LSB request, held until done
- lsb_to_mc_wr  in  1  1 = store, 0 = load
- lsb_to_mc_size  in  2  0 = byte, 1 = half, 2 = word (3 treated as word)
- lsb_to_mc_addr  in  32  access address
- lsb_to_mc_data  in  32  store data, low bytes used
- mc_to_lsb_done  out  1  one-cycle pulse: access complete
- mc_to_lsb_result  out  32  load bytes, zero-extended (sign extension is the LSB's job)
- mem_din  in  8  RAM read data, valid one cycle after address
- mem_dout  out  8  RAM write data
- mem_a  out  32  RAM address
- mem_wr  out  1  1 = write
- io_buffer_full  in  1  IO output buffer full

## Operation
- States: IDLE, IF_READ, LSB_READ, LSB_WRITE, DONE. Byte counter cnt (3 bits), length n = 1/2/4.
- IDLE grant: only one requester → grant it. Both → grant the one not served last (last_grant reg, reset = IF, so LSB wins first tie).
- Grant latches address, n, store data; IF_READ always n = 4.
- Read: at grant edge mem_a <= addr, mem_wr <= 0, cnt <= 0. Each following edge: capture mem_din into result byte cnt (bits 8*cnt+7:8*cnt), mem_a <= addr+cnt+1. At capture of byte n-1: done <= 1, mem_a <= 0, state <= DONE.
- Write: at grant edge mem_wr <= 1, mem_a <= addr, mem_dout <= data[7:0]. Each following edge drives next byte/address; after the edge carrying byte n-1, next edge sets mem_wr <= 0, mem_dout <= 0, mc_to_lsb_done <= 1, state <= DONE.
- IO stall: an address with addr[17:16] == 2'b11 and io_buffer_full = 1 is not driven; mem_wr stays/returns 0 and the write waits until io_buffer_full = 0. Reads are never stalled.
- DONE: done pulse falls, no grant this cycle (requester drops enable on the done edge), state <= IDLE.
- Clear: sampled in LSB_READ → state <= IDLE, mem_a <= 0, no done pulse (clear beats completion on the same edge). In IDLE, no LSB-load grant that cycle. IF_READ and LSB_WRITE are unaffected; committed stores and fetches always complete.
- Results hold their value until the next done for the same port; unused upper bytes are 0.

## Timing
- Reset values: mem_a = 0, mem_dout = 0, mem_wr = 0, both done = 0, both results = 0, state = IDLE, cnt = 0.
- Read of n bytes: request high at edge E → mem_a = addr after E → done high after edge E+n, low after E+n+1.
- Write of n bytes (no stall): mem_wr high after edges E … E+n-1, done high after E+n.
- Back-to-back: the earliest next grant is the edge after the DONE cycle (one dead cycle between accesses).
- rdy low: no edge has any effect, including counter, stall and clear handling.

## Test plan
- IF fetch at 0x0000_0010, RAM bytes 13,00,00,00 (hex) → mem_a walks 0x10..0x13, mc_to_if_result = 0x0000_0013, done one cycle after edge E+4.
- LSB LB at 0x104 with byte 0x80 → mc_to_lsb_result = 0x0000_0080; SH 0xBEEF at 0x200 → writes EF@0x200, BE@0x201, mem_wr high exactly 2 cycles.
- Both enables high from reset → LSB granted first, IF next (after dead cycle); repeated ties alternate.
- SB 0x41 to 0x30000 with io_buffer_full = 1 for 5 cycles → mem_wr stays 0 for 5 cycles, then one write, then done.
- LW in flight, clear pulsed after byte 1 → no mc_to_lsb_done, mem_a = 0, IDLE; the same pulse during IF_READ or SW → access completes with done.
- rst asserted mid-write → next cycle all outputs at reset values; rdy low for 3 cycles mid-read → mem_a and cnt frozen, result still correct.
